// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus controller.
package mem_bus_pkg;

   localparam int MEM_AW = 16;
   localparam int MEM_DW = 16;

   localparam logic MEM_RW_READ  = 1'b1;
   localparam logic MEM_RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_CAPTURE,
      ST_RELEASE,
      ST_RESP
   } state_t;

   // An errored access never returns data, even if some was captured before the fault.
   function automatic logic [MEM_DW-1:0] rsp_data_mask(input logic [MEM_DW-1:0] data,
                                                       input logic err);
      return err ? '0 : data;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_mfc_sync.sv
// Multi-flop synchroniser bringing the memory's asynchronous MFC into the clk domain.
// SYNC_STAGES must be at least 2.
module mfc_sync
   import mem_bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_bit,
   output logic sync_bit
);

   logic [SYNC_STAGES-1:0] chain;

   // Shift the raw MFC through the flop chain; the oldest sample is the synchronised value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], async_bit};
      end
   end

   assign sync_bit = chain[SYNC_STAGES-1];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus controller: one request at a time, full en/MFC strobe sequence, watchdog-bounded waits,
// result returned on a valid/ready response port.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int SYNC_STAGES    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rw,
   input  logic [MEM_AW-1:0] req_addr,
   input  logic [MEM_DW-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [MEM_DW-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [MEM_DW-1:0] mem_wdata,
   input  logic [MEM_DW-1:0] mem_rdata,
   input  logic              mem_mfc
);

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       wd_cnt;
   logic              timeout;
   logic              set_err;
   logic              accept;
   logic              mfc_s;
   logic              err_q;
   logic [MEM_DW-1:0] rdata_q;

   mfc_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_mfc_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_bit(mem_mfc),
      .sync_bit (mfc_s)
   );

   assign timeout = (wd_cnt == WD_LAST);
   assign accept  = (state == ST_IDLE) && req_valid;

   // Next-state decode and state-derived handshake outputs.
   always_comb begin
      state_nxt = state;
      set_err   = 1'b0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = ST_SETUP;
         end
         ST_SETUP: begin
            state_nxt = ST_STROBE;
         end
         ST_STROBE: begin
            if (mfc_s) begin
               state_nxt = ST_CAPTURE;
            end else if (timeout) begin
               set_err   = 1'b1;
               state_nxt = ST_RELEASE;
            end
         end
         ST_CAPTURE: begin
            state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (!mfc_s) begin
               state_nxt = ST_RESP;
            end else if (timeout) begin
               set_err   = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Watchdog: restarts on every state change, only counts while waiting on MFC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (state_nxt != state) begin
         wd_cnt <= '0;
      end else if (state == ST_STROBE || state == ST_RELEASE) begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end

   // Memory bus lines: loaded on accept, then frozen until the next accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rw    <= MEM_RW_READ;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (accept) begin
         mem_rw    <= req_rw;
         mem_addr  <= req_addr;
         mem_wdata <= req_wdata;
      end
   end

   // Strobe is registered from STROBE, so it rises one cycle after the bus settled in SETUP
   // and falls the cycle after CAPTURE; async reset drops it immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_en <= 1'b0;
      else        mem_en <= (state == ST_STROBE);
   end

   // Response register: cleared per access, read data latched in CAPTURE, error is sticky.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (set_err) err_q <= 1'b1;
         if (state == ST_CAPTURE && mem_rw == MEM_RW_READ && !err_q) rdata_q <= mem_rdata;
      end
   end

   assign rsp_rdata = rsp_data_mask(rdata_q, err_q);
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with a behavioural asynchronous-handshake memory.
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rw = 1'b1;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_en;
   logic        mem_rw;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_mfc = 1'b0;

   mem_bus_ctrl #(
      .TIMEOUT_CYCLES(64),
      .SYNC_STAGES   (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_rw   (req_rw),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .mem_en   (mem_en),
      .mem_rw   (mem_rw),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_mfc  (mem_mfc)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural memory: 0 = normal, 1 = dead (no MFC), 2 = MFC stuck high after first rise
   int          mfc_mode = 0;
   logic [15:0] mem [0:255];

   always @(mem_en) begin
      if (mem_en) begin
         if (mem_rw) mem_rdata = mem[mem_addr[7:0]];
         else        mem[mem_addr[7:0]] = mem_wdata;
         #2;
         if (mfc_mode != 1) mem_mfc = 1'b1;
      end else begin
         if (mfc_mode != 2) mem_mfc = 1'b0;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [15:0] rdata;
      logic        err;
   } rsp_t;
   rsp_t sb[$];

   int acc_cyc  = 0;
   int lat      = 0;
   int en_cnt   = 0;
   int en_first = 0;

   // Bus must not move while the strobe is high
   logic [15:0] prev_addr = '0;
   logic        prev_en   = 1'b0;
   always @(negedge clk) begin
      if (mem_en && prev_en) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
      prev_en   = mem_en;
      prev_addr = mem_addr;
   end

   task automatic send(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_d, input logic exp_e);
      int i;
      @(negedge clk);
      req_rw    = rw;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      i = 0;
      while (!req_ready && i < 20) begin
         @(negedge clk);
         i++;
      end
      chk("req_accept", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      acc_cyc   = cyc;
      sb.push_back('{rdata: exp_d, err: exp_e});
   endtask

   task automatic wait_rsp(input string tag, input int budget);
      rsp_t e;
      en_cnt   = 0;
      en_first = -1;
      lat      = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (mem_en) begin
            en_cnt++;
            if (en_first < 0) en_first = cyc - acc_cyc;
         end
         if (rsp_valid) break;
      end
      if (!rsp_valid) begin
         chk({tag, "_rsp_seen"}, 32'd0, 32'd1);
         void'(sb.pop_front());
         return;
      end
      lat = cyc - acc_cyc;
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      logic saw_rsp;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[3]  = 16'h2101;
      mem[1]  = 16'h1111;
      mem[32] = 16'h5A5A;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_rsp_err",   32'(rsp_err),   32'd0);
      chk("rst_mem_en",    32'(mem_en),    32'd0);
      chk("rst_mem_rw",    32'(mem_rw),    32'd1);
      chk("rst_mem_addr",  32'(mem_addr),  32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Plain read: strobe rises at accept+2, high through CAPTURE (4 cycles), latency 5+2*2
      send(1'b1, 16'h0003, 16'h0000, 16'h2101, 1'b0);
      wait_rsp("rd", 40);
      chk("rd_latency", 32'(lat), 32'd9);
      chk("rd_en_rise", 32'(en_first), 32'd2);
      chk("rd_en_cycles", 32'(en_cnt), 32'd4);
      finish_rsp("rd");

      // Write then read back
      send(1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
      wait_rsp("wr", 40);
      chk("wr_latency", 32'(lat), 32'd9);
      chk("wr_mem_content", 32'(mem[16]), 32'h0000BEEF);
      finish_rsp("wr");
      send(1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
      wait_rsp("rdback", 40);
      finish_rsp("rdback");

      // Dead memory: STROBE times out after 64 cycles
      mfc_mode = 1;
      send(1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b1);
      wait_rsp("to", 200);
      chk("to_en_cycles", 32'(en_cnt), 32'd64);
      chk("to_latency", 32'(lat), 32'd66);
      finish_rsp("to");

      // Stuck MFC: data captured but RELEASE times out, so data is suppressed
      mfc_mode = 2;
      send(1'b1, 16'h0001, 16'h0000, 16'h0000, 1'b1);
      wait_rsp("stuck", 200);
      chk("stuck_latency", 32'(lat), 32'd70);
      chk("stuck_en_cycles", 32'(en_cnt), 32'd4);
      mfc_mode = 0;
      mem_mfc  = 1'b0;
      finish_rsp("stuck");
      repeat (4) @(negedge clk);

      // Backpressure: response held stable, request pulses ignored
      rsp_ready = 1'b0;
      send(1'b1, 16'h0020, 16'h0000, 16'h5A5A, 1'b0);
      wait_rsp("bp", 40);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         req_addr  = 16'h0055;
         req_rw    = 1'b1;
         req_valid = (i % 2 == 0);
         chk("bp_valid_held", 32'(rsp_valid), 32'd1);
         chk("bp_rdata_held", 32'(rsp_rdata), 32'h5A5A);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_mem_addr", 32'(mem_addr), 32'h0020);
      end
      req_valid = 1'b0;
      finish_rsp("bp");
      saw_rsp = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         saw_rsp = saw_rsp | rsp_valid | mem_en;
      end
      chk("bp_not_queued", 32'(saw_rsp), 32'd0);

      // Reset mid-STROBE: strobe drops without a clock edge, no response
      send(1'b1, 16'h0003, 16'h0000, 16'h2101, 1'b0);
      for (int i = 0; i < 10 && !mem_en; i++) @(negedge clk);
      chk("mid_en_high", 32'(mem_en), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_en_async_low", 32'(mem_en), 32'd0);
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mid_req_ready", 32'(req_ready), 32'd1);
      void'(sb.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_rsp = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         saw_rsp = saw_rsp | rsp_valid;
      end
      chk("mid_no_rsp", 32'(saw_rsp), 32'd0);
      chk("mid_idle_ready", 32'(req_ready), 32'd1);

      // Recovery after reset
      send(1'b1, 16'h0001, 16'h0000, 16'h1111, 1'b0);
      wait_rsp("recover", 40);
      chk("recover_latency", 32'(lat), 32'd9);
      finish_rsp("recover");
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Synchronous bus controller between the CPU control unit and the asynchronous-handshake memory (en/rw/addr/in/out/MFC). It accepts one read or write request at a time on a valid/ready port and runs the full memory strobe sequence: address setup, `mem_en` rise, wait for synchronised MFC, capture, `mem_en` fall, wait for MFC release. It then returns read data or a write acknowledge on a valid/ready response port. A watchdog bounds every wait so a dead memory yields an error response instead of a hung CPU.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in STROBE or in RELEASE before the access is aborted with an error.
- `SYNC_STAGES`, 2: flop count of the `mem_mfc` synchroniser; must be ≥2.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle and able to accept.
- `req_rw`  in  1  1 = read, 0 = write (same encoding as memory `rw`).
- `req_addr`  in  16  word address.
- `req_wdata`  in  16  write data; ignored on reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  16  read data; 0 for writes and errors.
- `rsp_err`  out  1  access timed out.
- `mem_en`  out  1  memory strobe; memory acts on its rising edge.
- `mem_rw`  out  1  to memory `rw`.
- `mem_addr`  out  16  to memory `addr`.
- `mem_wdata`  out  16  to memory `in`.
- `mem_rdata`  in  16  from memory `out`.
- `mem_mfc`  in  1  memory function complete; asynchronous to `clk`.

## Operation
- FSM states: IDLE, SETUP, STROBE, CAPTURE, RELEASE, RESP.
- IDLE: `req_ready`=1, combinational from state. On `req_valid && req_ready`, register rw/addr/wdata onto `mem_rw`/`mem_addr`/`mem_wdata` and go to SETUP.
- SETUP: one cycle with `mem_en`=0 and bus stable. Then go to STROBE.
- STROBE: `mem_en`=1. Wait for `mfc_s`, the synchronised MFC.
  - `mfc_s`=1: go to CAPTURE.
  - Timeout: set err and go to RELEASE.
- CAPTURE: if reading and no err, latch `mem_rdata` into the response register. Otherwise the response register holds 0. Drop `mem_en` (registered, low from next cycle). Go to RELEASE.
- RELEASE: `mem_en`=0. Wait for `mfc_s`=0, then go to RESP.
  - Timeout here also sets err and goes to RESP. Data already captured is kept, but `rsp_rdata` is forced to 0 when err is set.
- RESP: `rsp_valid`=1. `rsp_rdata`/`rsp_err` are held stable until `rsp_ready`. On handshake go to IDLE.
- Watchdog: 16-bit counter, cleared on every state entry, increments each cycle in STROBE and in RELEASE. Timeout fires when count == TIMEOUT_CYCLES−1.
- `mem_addr`/`mem_wdata`/`mem_rw` hold their values from SETUP until the next accepted request. They never change while `mem_en`=1.
- Only one access is outstanding; `req_ready`=0 in every state except IDLE.
- A write produces a response with `rsp_rdata`=0 and `rsp_err`=0 as its acknowledge.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_en`=0, `mem_rw`=1, `mem_addr`=0, `mem_wdata`=0, synchroniser and counter 0.
- Accept at edge k: SETUP in cycle k+1, `mem_en` high from edge k+2.
- MFC assertion seen by FSM SYNC_STAGES edges after it is sampled.
- With MFC rising within one cycle of `mem_en`, minimum read latency from accept to `rsp_valid` = 5 + 2·SYNC_STAGES cycles (7 + 2·(SYNC_STAGES−1)).
- Reset asserted mid-access: `mem_en` falls asynchronously and no response is produced. The memory's MFC clears on the `mem_en` fall.
- `rsp_ready` held high in advance: RESP lasts exactly one cycle. Back-to-back requests are separated by one IDLE cycle.
- `req_valid` during any non-IDLE state is ignored and not queued.

## Structure
- Package `mem_bus_pkg`:
  - state enum;
  - `MEM_RW_READ`=1'b1, `MEM_RW_WRITE`=1'b0;
  - `MEM_AW`=16, `MEM_DW`=16.
- Sub-module `mfc_sync`: a SYNC_STAGES-deep flop chain with async active-low reset to 0, instantiated once for `mem_mfc`.

## Test plan
- Read: bench memory preloaded 0x0003 → 0x2101; request read 0x0003. Expect `rsp_rdata`=0x2101, `rsp_err`=0, latency 9 cycles at SYNC_STAGES=2, `mem_en` high for exactly the STROBE+CAPTURE span.
- Write then read: write 0xBEEF to 0x0010, then read 0x0010. Expect ack (`rsp_rdata`=0, `rsp_err`=0), then `rsp_rdata`=0xBEEF. `mem_addr` stable whenever `mem_en`=1.
- Timeout: `mem_mfc` tied 0, read 0x0001. Expect `mem_en` high for 64 cycles, then `rsp_err`=1 and `rsp_rdata`=0, `req_ready`=1 after handshake.
- Stuck MFC: `mem_mfc` tied 1 after first rise. Expect RELEASE timeout and `rsp_err`=1.
- Backpressure: `rsp_ready` low for 5 cycles during RESP. Expect `rsp_valid`/`rsp_rdata` unchanged and `req_valid` pulses ignored.
- Reset mid-STROBE: drop `rst_n` while `mem_en`=1. Expect `mem_en`=0 with no clock edge, no `rsp_valid`, IDLE with `req_ready`=1 after release.
